// File: rtl/rpn_cmd_sequencer.sv
// rpn_cmd_sequencer: decodes a valid/ready byte stream into stack-calculator commands,
// issues them as single apply pulses and halts on calculator or stream errors.
module rpn_cmd_sequencer #(
    parameter int CNT_W    = 16,
    parameter bit PRECHECK = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    input  logic [7:0]       s_data,
    output logic             s_ready,
    input  logic             clr,
    output logic             calc_apply,
    output logic [2:0]       calc_op,
    output logic [7:0]       calc_in,
    input  logic             calc_valid,
    input  logic             calc_empty,
    output logic             busy,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] cmd_cnt
);
    typedef enum logic [2:0] {IDLE, DATA, ISSUE, CHECK, ERROR} state_t;
    state_t     r_state;
    logic [7:0] r_in;
    logic [2:0] w_op;
    logic       w_bad;
    assign w_op  = s_data[2:0];
    assign w_bad = |s_data[7:3];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_in       <= '0;
            s_ready    <= 1'b1;
            calc_apply <= 1'b0;
            calc_op    <= '0;
            calc_in    <= '0;
            busy       <= 1'b0;
            err        <= 1'b0;
            err_code   <= 2'b00;
            cmd_cnt    <= '0;
        end else begin
            case (r_state)
                IDLE: if (s_valid) begin
                    if (w_bad) begin
                        r_state  <= ERROR;
                        s_ready  <= 1'b0;
                        err      <= 1'b1;
                        err_code <= 2'b11;
                    end else if (w_op == 3'd1) begin
                        r_state <= DATA;
                        busy    <= 1'b1;
                    end else if (w_op != 3'd0 && PRECHECK && calc_empty) begin
                        r_state  <= ERROR;
                        s_ready  <= 1'b0;
                        err      <= 1'b1;
                        err_code <= 2'b10;
                    end else if (w_op != 3'd0) begin
                        r_state    <= ISSUE;
                        s_ready    <= 1'b0;
                        busy       <= 1'b1;
                        calc_apply <= 1'b1;
                        calc_op    <= w_op;
                        calc_in    <= '0;
                    end
                end
                DATA: if (s_valid) begin
                    r_state    <= ISSUE;
                    r_in       <= s_data;
                    s_ready    <= 1'b0;
                    calc_apply <= 1'b1;
                    calc_op    <= 3'd1;
                    calc_in    <= s_data;
                end
                ISSUE: begin
                    // operand output reverts to the last pushed value once the strobe ends
                    r_state    <= CHECK;
                    calc_apply <= 1'b0;
                    calc_op    <= '0;
                    calc_in    <= r_in;
                end
                CHECK: begin
                    busy <= 1'b0;
                    if (calc_valid) begin
                        r_state <= IDLE;
                        s_ready <= 1'b1;
                        cmd_cnt <= cmd_cnt + 1'b1;
                    end else begin
                        r_state  <= ERROR;
                        err      <= 1'b1;
                        err_code <= 2'b01;
                    end
                end
                ERROR: if (clr) begin
                    r_state  <= IDLE;
                    s_ready  <= 1'b1;
                    err      <= 1'b0;
                    err_code <= 2'b00;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rpn_cmd_sequencer.sv
// tb_rpn_cmd_sequencer: directed scenario tests for the command sequencer, with a
// second 2-bit-counter instance sharing the stimulus for the wrap check.
module tb_rpn_cmd_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        clr = 1'b0;
    logic        calc_valid = 1'b1;
    logic        calc_empty = 1'b0;
    logic        s_ready, calc_apply, busy, err;
    logic [2:0]  calc_op;
    logic [7:0]  calc_in;
    logic [1:0]  err_code;
    logic [15:0] cmd_cnt;
    logic        s_ready2, calc_apply2, busy2, err2;
    logic [2:0]  calc_op2;
    logic [7:0]  calc_in2;
    logic [1:0]  err_code2;
    logic [1:0]  cmd_cnt2;
    int          errors = 0;
    int          checks = 0;
    logic [2:0]  q_op[$];
    logic [7:0]  q_in[$];

    rpn_cmd_sequencer #(.CNT_W(16), .PRECHECK(1'b1)) u_dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .clr(clr), .calc_apply(calc_apply), .calc_op(calc_op), .calc_in(calc_in),
        .calc_valid(calc_valid), .calc_empty(calc_empty), .busy(busy), .err(err),
        .err_code(err_code), .cmd_cnt(cmd_cnt)
    );

    rpn_cmd_sequencer #(.CNT_W(2), .PRECHECK(1'b1)) u_dut2 (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready2),
        .clr(clr), .calc_apply(calc_apply2), .calc_op(calc_op2), .calc_in(calc_in2),
        .calc_valid(calc_valid), .calc_empty(calc_empty), .busy(busy2), .err(err2),
        .err_code(err_code2), .cmd_cnt(cmd_cnt2)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (calc_apply) begin
        q_op.push_back(calc_op);
        q_in.push_back(calc_in);
    end

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        q_op.delete();
        q_in.delete();
    endtask

    task automatic send(input logic [7:0] b);
        s_valid = 1'b1;
        s_data  = b;
        for (int k = 0; k < 20 && !s_ready; k++) @(negedge clk);
        if (!s_ready) begin
            errors++;
            $display("FAIL send_timeout byte=%h s_ready=%b required 1", b, s_ready);
        end
        checks++;
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 20 && busy; k++) @(negedge clk);
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL busy_timeout busy=%b required 0", busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({s_ready, calc_apply, calc_op, calc_in, busy, err, err_code} !== {1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 2'b00}) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%b ap=%b op=%0d in=%h busy=%b err=%b code=%b", s_ready, calc_apply, calc_op, calc_in, busy, err, err_code);
        end
        checks++;
        if (cmd_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_cnt got %0d required 0", cmd_cnt);
        end
        do_reset();
    endtask

    task automatic test_push_div();
        do_reset();
        send(8'h01); send(8'h06); send(8'h01); send(8'h03); send(8'h05);
        wait_idle();
        checks++;
        if (q_op.size() != 3) begin
            errors++;
            $display("FAIL pd_pulses got %0d required 3", q_op.size());
        end else begin
            checks++;
            if ({q_op[0], q_op[1], q_op[2]} !== {3'd1, 3'd1, 3'd5}) begin
                errors++;
                $display("FAIL pd_ops got %0d %0d %0d required 1 1 5", q_op[0], q_op[1], q_op[2]);
            end
            checks++;
            if ({q_in[0], q_in[1], q_in[2]} !== {8'h06, 8'h03, 8'h00}) begin
                errors++;
                $display("FAIL pd_ins got %h %h %h required 06 03 00", q_in[0], q_in[1], q_in[2]);
            end
        end
        checks++;
        if (cmd_cnt !== 16'd3 || err !== 1'b0 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL pd_state got cnt=%0d err=%b rdy=%b required 3 0 1", cmd_cnt, err, s_ready);
        end
    endtask

    task automatic test_calc_invalid();
        do_reset();
        send(8'h01); send(8'h00); send(8'h01); send(8'h05);
        wait_idle();
        calc_valid = 1'b0;
        send(8'h05);
        wait_idle();
        checks++;
        if ({err, err_code, s_ready, busy} !== {1'b1, 2'b01, 1'b0, 1'b0} || cmd_cnt !== 16'd2) begin
            errors++;
            $display("FAIL inv_error got err=%b code=%b rdy=%b busy=%b cnt=%0d required 1 01 0 0 2", err, err_code, s_ready, busy, cmd_cnt);
        end
        s_valid = 1'b1;
        s_data  = 8'h02;
        repeat (5) @(negedge clk);
        s_valid = 1'b0;
        checks++;
        if (q_op.size() != 3 || err !== 1'b1 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL inv_hold got pulses=%0d err=%b rdy=%b required 3 1 0", q_op.size(), err, s_ready);
        end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checks++;
        if ({err, err_code, s_ready} !== {1'b0, 2'b00, 1'b1}) begin
            errors++;
            $display("FAIL inv_clr got err=%b code=%b rdy=%b required 0 00 1", err, err_code, s_ready);
        end
        send(8'h02);
        wait_idle();
        checks++;
        if ({err, err_code} !== {1'b1, 2'b01} || cmd_cnt !== 16'd2 || q_op.size() != 4) begin
            errors++;
            $display("FAIL inv_sticky got err=%b code=%b cnt=%0d pulses=%0d required 1 01 2 4", err, err_code, cmd_cnt, q_op.size());
        end
        calc_valid = 1'b1;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic test_underflow();
        logic [15:0] c0;
        c0 = cmd_cnt;
        q_op.delete();
        calc_empty = 1'b1;
        send(8'h02);
        checks++;
        if ({err, err_code, s_ready} !== {1'b1, 2'b10, 1'b0} || q_op.size() != 0) begin
            errors++;
            $display("FAIL uf_error got err=%b code=%b rdy=%b pulses=%0d required 1 10 0 0", err, err_code, s_ready, q_op.size());
        end
        calc_empty = 1'b0;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checks++;
        if ({err, err_code, s_ready, busy} !== {1'b0, 2'b00, 1'b1, 1'b0} || cmd_cnt !== c0) begin
            errors++;
            $display("FAIL uf_clr got err=%b code=%b rdy=%b busy=%b cnt=%0d required 0 00 1 0 %0d", err, err_code, s_ready, busy, cmd_cnt, c0);
        end
    endtask

    task automatic test_illegal_nop();
        logic [15:0] c0;
        c0 = cmd_cnt;
        q_op.delete();
        send(8'h2A);
        checks++;
        if ({err, err_code} !== {1'b1, 2'b11} || q_op.size() != 0) begin
            errors++;
            $display("FAIL ill_error got err=%b code=%b pulses=%0d required 1 11 0", err, err_code, q_op.size());
        end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        send(8'h00);
        repeat (3) @(negedge clk);
        checks++;
        if (q_op.size() != 0 || cmd_cnt !== c0 || {s_ready, busy, err} !== {1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL nop got pulses=%0d cnt=%0d rdy=%b busy=%b err=%b required 0 %0d 1 0 0", q_op.size(), cmd_cnt, s_ready, busy, err, c0);
        end
    endtask

    task automatic test_reset_mid_push();
        send(8'h01);
        checks++;
        if (busy !== 1'b1 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_data got busy=%b rdy=%b required 1 1", busy, s_ready);
        end
        do_reset();
        checks++;
        if ({busy, err, calc_apply} !== 3'b000 || cmd_cnt !== 16'd0) begin
            errors++;
            $display("FAIL mid_reset got busy=%b err=%b ap=%b cnt=%0d required 0 0 0 0", busy, err, calc_apply, cmd_cnt);
        end
        send(8'h07);
        wait_idle();
        checks++;
        if (q_op.size() != 1) begin
            errors++;
            $display("FAIL mid_next pulses=%0d required 1", q_op.size());
        end else begin
            checks++;
            if (q_op[0] !== 3'd7 || q_in[0] !== 8'h00 || cmd_cnt !== 16'd1) begin
                errors++;
                $display("FAIL mid_pop got op=%0d in=%h cnt=%0d required 7 00 1", q_op[0], q_in[0], cmd_cnt);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        calc_valid = 1'b1;
        calc_empty = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'h02;
        for (int n = 1; n <= 15; n++) begin
            @(negedge clk);
            checks++;
            if (calc_apply2 !== (n % 3 == 1)) begin
                errors++;
                $display("FAIL b2b_apply cycle=%0d got %b required %b", n, calc_apply2, (n % 3 == 1));
            end
            if (n % 3 == 0) begin
                checks++;
                if (cmd_cnt2 !== 2'((n / 3) % 4)) begin
                    errors++;
                    $display("FAIL b2b_cnt cycle=%0d got %0d required %0d", n, cmd_cnt2, (n / 3) % 4);
                end
            end
        end
        s_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_push_div();
        test_calc_invalid();
        test_underflow();
        test_illegal_nop();
        test_reset_mid_push();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
